// File: rtl/pipe_ctrl.sv
// Pipeline hazard and redirect controller: per-stage stall/flush, PC redirect,
// stale-fetch discard after a redirect, fetch-timeout detection and bubble counting.
module pipe_ctrl #(
    parameter int unsigned STAGES        = 5,
    parameter int unsigned EX_IDX        = 2,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned FETCH_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_data_valid_i,
    input  logic              ex_branch_flag_i,
    input  logic [ADDR_W-1:0] ex_pc_new_i,
    input  logic              ex_busy_i,
    input  logic              id_load_use_i,
    output logic [STAGES-1:0] stall_o,
    output logic [STAGES-1:0] flush_o,
    output logic              pc_load_o,
    output logic [ADDR_W-1:0] pc_new_o,
    output logic              fetch_timeout_o,
    output logic [31:0]       bubble_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(FETCH_TIMEOUT + 1);

    localparam logic [STAGES-1:0] ONE         = STAGES'(1);
    localparam logic [STAGES-1:0] UPTO_EX     = (ONE << (EX_IDX + 1)) - ONE;
    localparam logic [STAGES-1:0] STALL_BUSY  = UPTO_EX;
    localparam logic [STAGES-1:0] FLUSH_BUSY  = ONE << (EX_IDX + 1);
    localparam logic [STAGES-1:0] FLUSH_BR    = UPTO_EX & ~ONE;
    localparam logic [STAGES-1:0] STALL_LU    = (ONE << EX_IDX) - ONE;
    localparam logic [STAGES-1:0] FLUSH_LU    = ONE << EX_IDX;
    localparam logic [STAGES-1:0] STALL_FETCH = ONE;
    localparam logic [STAGES-1:0] FLUSH_FETCH = ONE << 1;

    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(FETCH_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(FETCH_TIMEOUT - 1);

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [STAGES-1:0] stall_raw;
    logic [STAGES-1:0] flush_raw;
    logic              pc_load;
    logic [WAIT_W-1:0] wait_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and stall/flush/redirect decode; reset forces a full flush
    always_comb begin
        state_next = state;
        stall_raw  = '0;
        flush_raw  = '0;
        pc_load    = 1'b0;

        case (state)
            RUN: begin
                if (ex_busy_i) begin
                    stall_raw = STALL_BUSY;
                    flush_raw = FLUSH_BUSY;
                end else if (ex_branch_flag_i) begin
                    pc_load   = 1'b1;
                    flush_raw = FLUSH_BR;
                    if (!icache_data_valid_i) begin
                        state_next = REDIR_WAIT;
                    end
                end else if (id_load_use_i) begin
                    stall_raw = STALL_LU;
                    flush_raw = FLUSH_LU;
                end else if (!icache_data_valid_i) begin
                    stall_raw = STALL_FETCH;
                    flush_raw = FLUSH_FETCH;
                end
            end
            REDIR_WAIT: begin
                // Old-PC fetch still in flight: hold PC, discard whatever IF returns
                stall_raw = STALL_FETCH;
                flush_raw = FLUSH_FETCH;
                if (ex_busy_i) begin
                    stall_raw = stall_raw | STALL_BUSY;
                    flush_raw = flush_raw | FLUSH_BUSY;
                end else if (ex_branch_flag_i) begin
                    pc_load   = 1'b1;
                    flush_raw = flush_raw | FLUSH_BR;
                end else if (icache_data_valid_i) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase

        if (!rst) begin
            state_next = RUN;
            stall_raw  = '0;
            flush_raw  = '1;
            pc_load    = 1'b0;
        end
    end

    // Flush overrides stall on the same register
    assign stall_o   = stall_raw & ~flush_raw;
    assign flush_o   = flush_raw;
    assign pc_load_o = pc_load;
    assign pc_new_o  = pc_load ? ex_pc_new_i : '0;

    // Consecutive invalid-fetch counter with sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt        <= '0;
            fetch_timeout_o <= 1'b0;
        end else begin
            if (icache_data_valid_i) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (!icache_data_valid_i && (wait_cnt >= WAIT_LAST)) begin
                fetch_timeout_o <= 1'b1;
            end
        end
    end

    // Bubble performance counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!rst) begin
            bubble_cnt_o <= '0;
        end else if (|flush_raw) begin
            bubble_cnt_o <= bubble_cnt_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (5 stages, EX at index 2, timeout 4).
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        branch;
    logic [31:0] pc_in;
    logic        busy;
    logic        load_use;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        pc_load;
    logic [31:0] pc_new;
    logic        timeout;
    logic [31:0] bubbles;

    int vectors;
    int miscompares;

    pipe_ctrl #(
        .STAGES(5),
        .EX_IDX(2),
        .ADDR_W(32),
        .FETCH_TIMEOUT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .icache_data_valid_i(valid),
        .ex_branch_flag_i(branch),
        .ex_pc_new_i(pc_in),
        .ex_busy_i(busy),
        .id_load_use_i(load_use),
        .stall_o(stall),
        .flush_o(flush),
        .pc_load_o(pc_load),
        .pc_new_o(pc_new),
        .fetch_timeout_o(timeout),
        .bubble_cnt_o(bubbles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic [4:0] s, input logic [4:0] f,
                       input logic pl, input logic [31:0] pn);
        chk({tag, ".stall"}, 32'(stall), 32'(s));
        chk({tag, ".flush"}, 32'(flush), 32'(f));
        chk({tag, ".pc_load"}, 32'(pc_load), 32'(pl));
        chk({tag, ".pc_new"}, pc_new, pn);
    endtask

    task automatic drive(input logic v, input logic br, input logic [31:0] pc,
                         input logic bz, input logic lu);
        valid    = v;
        branch   = br;
        pc_in    = pc;
        busy     = bz;
        load_use = lu;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        drive(1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b0);

        // Reset forces full flush even with a branch pending
        @(posedge clk);
        #1;
        ctl("reset", 5'b00000, 5'b11111, 1'b0, 32'h0);
        tick();
        ctl("reset2", 5'b00000, 5'b11111, 1'b0, 32'h0);
        chk("reset.bubbles", bubbles, 32'd0);
        chk("reset.timeout", 32'(timeout), 32'd0);

        // Idle run
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        ctl("idle", 5'b00000, 5'b00000, 1'b0, 32'h0);
        tick();
        chk("idle.bubbles", bubbles, 32'd0);

        // Branch with valid fetch stays in RUN
        drive(1'b1, 1'b1, 32'h8000_0040, 1'b0, 1'b0);
        ctl("br_v", 5'b00000, 5'b00110, 1'b1, 32'h8000_0040);
        tick();
        chk("br_v.bubbles", bubbles, 32'd1);
        drive(1'b1, 1'b0, 32'h8000_0040, 1'b0, 1'b0);
        ctl("br_v.after", 5'b00000, 5'b00000, 1'b0, 32'h0);
        tick();

        // Branch with invalid fetch enters REDIR_WAIT until a valid cycle
        drive(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
        ctl("br_nv", 5'b00000, 5'b00110, 1'b1, 32'h0000_0100);
        tick();
        drive(1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        ctl("rw1", 5'b00001, 5'b00010, 1'b0, 32'h0);
        tick();
        ctl("rw2", 5'b00001, 5'b00010, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        ctl("rw3", 5'b00001, 5'b00010, 1'b0, 32'h0);
        tick();
        chk("rw.bubbles", bubbles, 32'd5);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        ctl("rw.exit", 5'b00000, 5'b00000, 1'b0, 32'h0);
        tick();

        // Second redirect while waiting keeps REDIR_WAIT; load-use ignored there
        drive(1'b0, 1'b1, 32'h0000_0200, 1'b0, 1'b0);
        ctl("br2", 5'b00000, 5'b00110, 1'b1, 32'h0000_0200);
        tick();
        drive(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0);
        ctl("rw.br", 5'b00001, 5'b00110, 1'b1, 32'h0000_0300);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        ctl("rw.lu", 5'b00001, 5'b00010, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        ctl("rw2.exit", 5'b00000, 5'b00000, 1'b0, 32'h0);
        chk("rw2.bubbles", bubbles, 32'd8);
        tick();

        // EX busy dominates branch and load-use
        drive(1'b1, 1'b1, 32'h0000_0400, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            ctl("busy", 5'b00111, 5'b01000, 1'b0, 32'h0);
            tick();
        end
        chk("busy.bubbles", bubbles, 32'd11);

        // Load-use alone
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        ctl("lu", 5'b00011, 5'b00100, 1'b0, 32'h0);
        tick();
        chk("lu.bubbles", bubbles, 32'd12);

        // Fetch timeout after 4 consecutive invalid cycles, sticky
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ctl("nv", 5'b00001, 5'b00010, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        chk("to.edge3", 32'(timeout), 32'd0);
        tick();
        chk("to.edge4", 32'(timeout), 32'd1);
        chk("to.bubbles", bubbles, 32'd16);
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        chk("to.sticky", 32'(timeout), 32'd1);
        rst = 1'b0;
        tick();
        chk("to.clear", 32'(timeout), 32'd0);
        chk("to.bubclr", bubbles, 32'd0);

        // Reset mid-REDIR_WAIT returns to RUN
        rst = 1'b1;
        drive(1'b0, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        ctl("rst_rw", 5'b00000, 5'b00000, 1'b0, 32'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
